// File: rtl/rng_pkg.sv
// Shared types and constants for the random-number arbiter slice.
package rng_pkg;

  typedef enum logic [1:0] {
    RESEED = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } rng_state_e;

  localparam int                RND_W        = 5;
  localparam int                RESEED_CNT_W = 8;
  localparam logic [RND_W-1:0]  SEED_DEFAULT = 5'd1;

  // Seed counter walks 1..31 and never lands on the all-zero lock-up value.
  function automatic logic [RND_W-1:0] next_seed(input logic [RND_W-1:0] s);
    return (s == '1) ? SEED_DEFAULT : s + 5'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [PW-1:0]      winner,
  output logic               any
);

  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    winner = '0;
    any    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/rng_arbiter.sv
// Owns the 5-bit generator's seed/reset, detects zero lock-up, and hands out
// one registered random sample per cycle to round-robin requesters.
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int STUCK_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [RND_W-1:0]        rnd_in,
  output logic                    rng_rstn_o,
  output logic [RND_W-1:0]        seed_o,
  input  logic [NUM_REQ-1:0]      req,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [RND_W-1:0]        rnd_out,
  output logic                    rnd_valid,
  input  logic                    reseed_i,
  input  logic [RND_W-1:0]        seed_i,
  output logic [RESEED_CNT_W-1:0] reseed_cnt
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = $clog2(STUCK_CYCLES);

  rng_state_e        r_state, w_state_nxt;
  logic [RND_W-1:0]  r_seed_ctr;
  logic [RND_W-1:0]  r_rnd_prev;
  logic [SW-1:0]     r_stuck_cnt;
  logic [PW-1:0]     r_rr_ptr;
  logic              r_use_ctr;

  logic [PW-1:0]     w_winner, w_ptr_nxt;
  logic              w_any;
  logic              w_equal, w_stuck, w_reseed, w_grant;
  logic [RND_W-1:0]  w_seed_sel;
  logic              w_sel_ctr;

  rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (r_rr_ptr),
    .winner (w_winner),
    .any    (w_any)
  );

  assign w_ptr_nxt = (w_winner == PW'(NUM_REQ - 1)) ? '0 : w_winner + PW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_equal     = (rnd_in == r_rnd_prev);
    w_stuck     = 1'b0;
    w_reseed    = 1'b0;
    w_grant     = 1'b0;
    w_seed_sel  = r_seed_ctr;
    w_sel_ctr   = 1'b1;
    if (reseed_i && seed_i != '0) begin
      w_seed_sel = seed_i;
      w_sel_ctr  = 1'b0;
    end
    case (r_state)
      RESEED: w_state_nxt = SETTLE;
      SETTLE: w_state_nxt = RUN;
      RUN: begin
        w_stuck  = w_equal && (r_stuck_cnt == SW'(STUCK_CYCLES - 1));
        w_reseed = w_stuck || reseed_i;
        w_grant  = !w_reseed && w_any;
        if (w_reseed) w_state_nxt = RESEED;
      end
      default: w_state_nxt = RESEED;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!rstn) r_state <= RESEED;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    // NOTE: only control and status registers are reset; there is no memory here to clear.
    if (!rstn) begin
      r_seed_ctr  <= SEED_DEFAULT;
      seed_o      <= SEED_DEFAULT;
      rng_rstn_o  <= 1'b0;
      r_use_ctr   <= 1'b1;
      gnt         <= '0;
      rnd_out     <= '0;
      rnd_valid   <= 1'b0;
      reseed_cnt  <= '0;
      r_rr_ptr    <= '0;
      r_stuck_cnt <= '0;
      r_rnd_prev  <= '0;
    end else begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      case (r_state)
        RESEED: begin
          if (reseed_cnt != '1) reseed_cnt <= reseed_cnt + RESEED_CNT_W'(1);
          // The seed counter is consumed here so the reset reseed also advances it.
          if (r_use_ctr) r_seed_ctr <= next_seed(r_seed_ctr);
          rng_rstn_o <= 1'b1;
        end
        SETTLE: begin
          r_stuck_cnt <= '0;
          r_rnd_prev  <= '0;
        end
        RUN: begin
          r_rnd_prev <= rnd_in;
          if (!w_equal)                                  r_stuck_cnt <= '0;
          else if (r_stuck_cnt != SW'(STUCK_CYCLES - 1)) r_stuck_cnt <= r_stuck_cnt + SW'(1);
          if (w_reseed) begin
            rng_rstn_o <= 1'b0;
            seed_o     <= w_seed_sel;
            r_use_ctr  <= w_sel_ctr;
          end
          if (w_grant) begin
            gnt       <= NUM_REQ'(1) << w_winner;
            rnd_out   <= rnd_in;
            rnd_valid <= 1'b1;
            r_rr_ptr  <= w_ptr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_arbiter.sv
// Self-checking bench: LFSR generator model, spec-level arbiter model, per-cycle compare.
module tb_rng_arbiter;

  localparam int N  = 4;
  localparam int SC = 3;

  logic         clk = 1'b0;
  logic         rstn;
  logic [4:0]   rnd_in, seed_o, seed_i, rnd_out;
  logic         rng_rstn_o, rnd_valid, reseed_i;
  logic [N-1:0] req, gnt;
  logic [7:0]   reseed_cnt;

  always #5 clk = ~clk;

  rng_arbiter #(.NUM_REQ(N), .STUCK_CYCLES(SC)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rnd_in     (rnd_in),
    .rng_rstn_o (rng_rstn_o),
    .seed_o     (seed_o),
    .req        (req),
    .gnt        (gnt),
    .rnd_out    (rnd_out),
    .rnd_valid  (rnd_valid),
    .reseed_i   (reseed_i),
    .seed_i     (seed_i),
    .reseed_cnt (reseed_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] lfsr(input logic [4:0] x);
    return {x[3:0], x[4] ^ x[1]};
  endfunction

  // Spec-level model: phase 0 = reseed, 1 = settle, 2 = run.
  int m_phase, m_seed_ctr, m_ptr, m_rep, m_prev;
  bit m_use_ctr;
  int e_gnt, e_valid, e_rnd, e_seed, e_rrst, e_cnt;

  task automatic model_edge(input bit p_rstn, input bit [N-1:0] p_req, input bit p_rs,
                            input int p_seed, input int p_rnd);
    bit same, stuck, found;
    if (!p_rstn) begin
      m_phase = 0; m_seed_ctr = 1; m_ptr = 0; m_rep = 0; m_prev = 0; m_use_ctr = 1;
      e_seed = 1; e_rrst = 0; e_gnt = 0; e_rnd = 0; e_valid = 0; e_cnt = 0;
    end else begin
      e_gnt = 0; e_valid = 0;
      if (m_phase == 0) begin
        if (e_cnt < 255) e_cnt++;
        if (m_use_ctr) m_seed_ctr = (m_seed_ctr == 31) ? 1 : m_seed_ctr + 1;
        e_rrst = 1; m_phase = 1;
      end else if (m_phase == 1) begin
        m_rep = 0; m_prev = 0; m_phase = 2;
      end else begin
        same  = (p_rnd == m_prev);
        stuck = same && (m_rep >= SC - 1);
        m_rep = same ? ((m_rep < SC - 1) ? m_rep + 1 : m_rep) : 0;
        m_prev = p_rnd;
        if (p_rs || stuck) begin
          m_phase = 0; e_rrst = 0;
          if (p_rs && p_seed != 0) begin e_seed = p_seed; m_use_ctr = 0; end
          else begin e_seed = m_seed_ctr; m_use_ctr = 1; end
        end else begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (!found && p_req[idx]) begin
              found = 1; e_gnt = 1 << idx; e_rnd = p_rnd; e_valid = 1; m_ptr = (idx + 1) % N;
            end
          end
        end
      end
    end
  endtask

  logic [4:0]   gen = 5'd7;
  bit   [N-1:0] want = '0;

  task automatic step();
    bit         p_rstn, p_rs, p_rrst;
    bit [N-1:0] p_req;
    int         p_seed, p_rnd;
    logic [4:0] p_seedo;
    p_rstn = rstn; p_req = req; p_rs = reseed_i; p_seed = int'(seed_i); p_rnd = int'(rnd_in);
    p_rrst = (rng_rstn_o === 1'b1); p_seedo = seed_o;
    @(posedge clk); #1;
    gen    = p_rrst ? lfsr(gen) : p_seedo;
    rnd_in = gen;
    model_edge(p_rstn, p_req, p_rs, p_seed, p_rnd);
    req = want & ~gnt;
  endtask

  task automatic set_want(input bit [N-1:0] m);
    want = m;
    req  = want & ~gnt;
  endtask

  always @(negedge clk) begin
    if (checking) begin
      check("gnt",        32'(gnt),        32'(e_gnt));
      check("rnd_valid",  32'(rnd_valid),  32'(e_valid));
      check("rng_rstn_o", 32'(rng_rstn_o), 32'(e_rrst));
      check("seed_o",     32'(seed_o),     32'(e_seed));
      check("reseed_cnt", 32'(reseed_cnt), 32'(e_cnt));
      if (e_valid != 0) check("rnd_out", 32'(rnd_out), 32'(e_rnd));
    end
  end

  logic [4:0] vals [4];

  initial begin
    rstn = 1'b0; req = '0; reseed_i = 1'b0; seed_i = '0; rnd_in = gen;
    step();
    checking = 1'b1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rnd_out", 32'(rnd_out), 0);
    check("rst_cnt", 32'(reseed_cnt), 0);
    step();

    // Test 1: reset sequence
    rstn = 1'b1;
    check("t1_rstn_low", 32'(rng_rstn_o), 0);
    check("t1_seed1", 32'(seed_o), 1);
    step();
    check("t1_rstn_high", 32'(rng_rstn_o), 1);
    check("t1_cnt1", 32'(reseed_cnt), 1);
    check("t1_gen_seeded", 32'(rnd_in), 1);
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      check("t1_no_gnt", 32'(gnt), 0);
    end

    // Test 2: all four requesting, rotating grants with consecutive generator states
    set_want(4'b1111);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) want = '0;
      step();
      check("t2_gnt", 32'(gnt), 32'(1 << k));
      vals[k] = rnd_out;
    end
    check("t2_nonzero", 32'(vals[0] != 0), 1);
    for (int k = 1; k < 4; k++) check("t2_next_state", 32'(vals[k]), 32'(lfsr(vals[k-1])));
    step();

    // Test 3: single requester granted every other cycle; pointer ends at 3
    set_want(4'b0100);
    for (int k = 0; k < 8; k++) begin
      step();
      check("t3_gnt", 32'(gnt), (k % 2 == 0) ? 32'h4 : 32'h0);
    end
    set_want(4'b1111);
    want = '0;
    step();
    check("t3_ptr3", 32'(gnt), 32'h8);
    step();

    // Test 4: command reseeds with seed_i=0 use the counter; forced zero auto-reseeds
    reseed_i = 1'b1; seed_i = 5'd0;
    step();
    reseed_i = 1'b0;
    check("t4_seed2", 32'(seed_o), 2);
    check("t4_rstn_low", 32'(rng_rstn_o), 0);
    step(); step();
    reseed_i = 1'b1;
    step();
    reseed_i = 1'b0;
    check("t4_seed3", 32'(seed_o), 3);
    step(); step();
    gen = 5'd0; rnd_in = 5'd0;
    begin
      int n;
      n = 0;
      while (rng_rstn_o !== 1'b0 && n < 12) begin
        step();
        n++;
      end
      check("t4_auto_reseed_seen", 32'(rng_rstn_o === 1'b0), 1);
    end
    check("t4_auto_seed4", 32'(seed_o), 4);
    step(); step();
    check("t4_resumes_nonzero", 32'(rnd_in != 0), 1);

    // Test 5: command reseed with seed 9 beats a same-cycle request
    set_want(4'b0001);
    reseed_i = 1'b1; seed_i = 5'd9;
    step();
    reseed_i = 1'b0; seed_i = 5'd0;
    check("t5_no_gnt_reseed", 32'(gnt), 0);
    check("t5_seed9", 32'(seed_o), 9);
    step();
    check("t5_no_gnt_settle", 32'(gnt), 0);
    step();
    check("t5_no_gnt_run0", 32'(gnt), 0);
    step();
    check("t5_gnt_after", 32'(gnt), 1);
    want = '0;
    reseed_i = 1'b1;
    step();
    reseed_i = 1'b0;
    check("t5_ctr_unchanged", 32'(seed_o), 5);
    step(); step();

    // Test 6: reset in the middle of a grant stream
    set_want(4'b1111);
    step(); step(); step();
    rstn = 1'b0;
    step();
    check("t6_gnt0", 32'(gnt), 0);
    check("t6_cnt0", 32'(reseed_cnt), 0);
    check("t6_seed1", 32'(seed_o), 1);
    want = '0; req = '0; rstn = 1'b1;
    step();
    check("t6_cnt1", 32'(reseed_cnt), 1);
    step();
    set_want(4'b1111);
    want = '0;
    step();
    check("t6_ptr_reset", 32'(gnt), 1);

    // Randomized traffic, reseeds, lock-ups and resets against the model
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 15) == 0) want = N'($urandom);
      reseed_i = ($urandom_range(0, 39) == 0);
      seed_i   = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      rstn     = ($urandom_range(0, 299) != 0);
      req      = want & ~gnt;
      step();
      if ($urandom_range(0, 99) == 0) begin gen = 5'd0; rnd_in = 5'd0; end
    end
    want = '0; req = '0; reseed_i = 1'b0; seed_i = '0;

    // Reseed counter saturation and seed counter wrap
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step(); step();
    for (int k = 0; k < 300; k++) begin
      reseed_i = 1'b1;
      step();
      reseed_i = 1'b0;
      step(); step();
    end
    check("sat_cnt255", 32'(reseed_cnt), 255);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rng_arbiter.md
Name: rng_arbiter

Overview:
- Owns the single 5-bit pseudo-random generator (randomNumberGenerator) and shares its output among NUM_REQ game requesters: fruit spawn x, fruit type, launch velocity, and bomb chance.
- Controls the generator's seed and reset: it drives the generator's rstn and seed inputs, and its data output feeds back as rnd_in.
- Grants at most one requester per cycle, round-robin, with a registered sample, so no two grants ever receive the same generator state.
- Detects a stuck generator (the all-zero lock-up) and reseeds it automatically. Also reseeds on command, for example at game start.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- STUCK_CYCLES, 3, consecutive cycles of an unchanged rnd_in that count as "stuck" (>=2).

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- rnd_in  in  5  generator data output.
- rng_rstn_o  out  1  drives the generator's rstn. The generator loads seed_o while this is low.
- seed_o  out  5  drives the generator's seed input.
- req  in  NUM_REQ  level requests. A requester holds its bit high until it receives a grant.
- gnt  out  NUM_REQ  one-hot, single-cycle grant pulse.
- rnd_out  out  5  random value delivered with the grant. Valid only while rnd_valid=1.
- rnd_valid  out  1  high exactly when gnt is non-zero.
- reseed_i  in  1  single-cycle reseed command.
- seed_i  in  5  seed used with reseed_i. A value of 0 is replaced by seed_ctr.
- reseed_cnt  out  8  saturating count of reseeds of all causes, including the reset reseed.

Behaviour:
- All outputs and state are registered. Reset is sampled only on a clk edge.
- Reset values:
  - state=RESEED, seed_ctr=5'd1, seed_o=5'd1, rng_rstn_o=0.
  - gnt=0, rnd_out=0, rnd_valid=0, reseed_cnt=0.
  - rr_ptr=0, stuck_cnt=0, rnd_prev=0.
- States: RESEED -> SETTLE -> RUN.
  - RESEED (1 cycle): rng_rstn_o=0 and seed_o holds the chosen seed. reseed_cnt increments, saturating at 255. Next state is SETTLE.
  - SETTLE (1 cycle): rng_rstn_o=1. stuck_cnt and rnd_prev are cleared. Next state is RUN.
  - RUN: normal operation, described below.
- No grants are issued in RESEED or SETTLE: gnt=0 and rnd_valid=0. Requests stay pending; they are not dropped.
- Seed choice:
  - Auto reseed uses seed_ctr, then seed_ctr advances by +1, wrapping 31 -> 1 and never producing 0.
  - Command reseed uses seed_i if it is non-zero. If seed_i=0, it uses seed_ctr and advances seed_ctr.
- Stuck detection (RUN only):
  - rnd_prev <= rnd_in every cycle.
  - If rnd_in==rnd_prev, stuck_cnt increments, saturating; otherwise stuck_cnt clears.
  - When stuck_cnt reaches STUCK_CYCLES-1 and another equal sample arrives, the next state is RESEED.
  - With this generator, 0 is the only fixed point.
- Arbitration (RUN, no reseed this cycle):
  - The winner is the first set req bit searching from rr_ptr upward, with wrap.
  - Next cycle: gnt=onehot(winner), rnd_out = rnd_in as sampled in the arbitration cycle, rnd_valid=1, and rr_ptr=(winner+1) mod NUM_REQ.
  - Grant latency is 1 cycle from the sampled request.
  - Requesters drop req in the cycle gnt is seen. A req still high in the gnt cycle counts as a new request.
  - With a single active requester, it is granted every other cycle.
- Simultaneous events:
  - reseed_i in the same cycle as a stuck detection: one reseed only, using the command-seed rules.
  - reseed_i has priority over arbitration in the same cycle: no grant is issued.
  - reseed_i during RESEED or SETTLE is ignored.
  - An already-registered grant pulse still completes during the RESEED cycle. Its rnd_out was sampled before the reseed decision.
- Reset mid-operation: an outstanding grant is lost. The block returns to RESEED with seed 1, and reseed_cnt restarts from 0.

Decomposition:
- Package rng_pkg holds:
  - the state enum (RESEED, SETTLE, RUN);
  - RND_W=5;
  - SEED_DEFAULT=5'd1;
  - the reseed_cnt width of 8.
- Sub-module rr_pick (combinational round-robin picker). Inputs: req, ptr. Outputs: winner index, any.

Test Plan:
1. Release reset, model generator attached, no requests -> rng_rstn_o low 1 cycle after reset with seed_o=1, then SETTLE, then RUN. reseed_cnt=1 and no gnt.
2. req=4'b1111 held continuously (released only on grant) -> gnt cycles 0001,0010,0100,1000. Each rnd_out equals the model state 1 cycle before its grant, and all four values are distinct consecutive generator states.
3. req=4'b0100 only -> gnt=0100 every other cycle; rr_ptr=3 after each grant.
4. reseed_i=1 with seed_i=0, then force the generator to 0 via reseed with seed_i=0 replaced -> first reseed uses seed 2 (seed_ctr advances to 3). A separate run with the generator forced to 0 for 3 cycles -> auto RESEED with seed_o=seed_ctr, and the sequence resumes non-zero.
5. reseed_i=1 with seed_i=5'd9 in the same cycle as req=0001 -> no grant that cycle. seed_o=9 in RESEED, the grant is issued after SETTLE, and seed_ctr is unchanged.
6. rstn low for 1 cycle in the middle of a stream of grants -> gnt=0 and reseed_cnt=0 at the next edge, then the reset sequence of test 1 repeats.
